// File: rtl/cache_mem_arbiter_if.sv
// Bus types and interface for the cache/memory arbiter.
//
// mem_req_type  : addr[31:0], data[127:0], rw (1 = write), valid
// mem_data_type : data[127:0], ready
//
// Handshake: a requester raises req.valid with all fields stable and holds
// them until it sees its data.ready (a one-cycle pulse), then drops valid in
// the following cycle. Toward memory, mem_req_o.valid is a one-cycle issue
// pulse and mem_data_i.ready is only honoured while a transaction waits.
//
// Modports:
//   slave  : the arbiter (takes requests and memory responses, drives
//            requester responses and the memory request)
//   master : the environment (caches plus memory model)

package cache_mem_arbiter_pkg;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

endpackage

interface cache_mem_arbiter_if;
  import cache_mem_arbiter_pkg::*;

  mem_req_type  req0_i;
  mem_req_type  req1_i;
  mem_data_type data0_o;
  mem_data_type data1_o;
  mem_req_type  mem_req_o;
  mem_data_type mem_data_i;

  modport slave (
    input  req0_i,
    input  req1_i,
    input  mem_data_i,
    output data0_o,
    output data1_o,
    output mem_req_o
  );

  modport master (
    output req0_i,
    output req1_i,
    output mem_data_i,
    input  data0_o,
    input  data1_o,
    input  mem_req_o
  );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Two-port round-robin arbiter sharing one backing memory between the
// instruction cache (port 0) and the data cache (port 1). One 128-bit line
// transaction is in flight at a time; a watchdog aborts transactions the
// memory never answers.
//
// Ports:
//   clk_i    : clock, all state on rising edge
//   rst_i    : asynchronous active-high reset
//   bus      : cache_mem_arbiter_if.slave (req0_i, req1_i, data0_o, data1_o,
//              mem_req_o, mem_data_i)
//   owner_o  : port currently granted, meaningful while busy_o = 1
//   busy_o   : 1 whenever the FSM is not IDLE
//   err_o    : one-cycle pulse together with a timed-out response
//   state_o  : FSM state for debug (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Parameter:
//   TIMEOUT  : WAIT cycles without memory ready before abort (1..255)

module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cache_mem_arbiter_if.slave     bus,
  output logic                   owner_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Counter value in the last WAIT cycle before the watchdog fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e       state_q;
  logic         last_q;      // port granted most recently
  logic         owner_q;
  logic         busy_q;
  logic         err_q;
  logic [7:0]   cnt_q;
  mem_req_type  mem_req_q;
  mem_data_type data0_q;
  mem_data_type data1_q;

  logic         win;
  logic         any_req;
  mem_req_type  win_req;

  // On a tie the port not granted last wins; otherwise the lone requester.
  // The winner always has valid set, so win_req can be latched whole.
  always_comb begin
    any_req = bus.req0_i.valid | bus.req1_i.valid;
    win     = (bus.req0_i.valid & bus.req1_i.valid) ? ~last_q : bus.req1_i.valid;
    win_req = win ? bus.req1_i : bus.req0_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
      mem_req_q <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 8'd0;
          if (any_req) begin
            owner_q   <= win;
            mem_req_q <= win_req;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end

        ISSUE: begin
          // Issue pulse lasts one cycle; address, data and rw stay held.
          mem_req_q.valid <= 1'b0;
          cnt_q           <= 8'd0;
          state_q         <= WAIT;
        end

        WAIT: begin
          // Memory ready takes priority over a watchdog expiry in the same cycle.
          if (bus.mem_data_i.ready) begin
            if (owner_q) begin
              data1_q.data  <= mem_req_q.rw ? 128'h0 : bus.mem_data_i.data;
              data1_q.ready <= 1'b1;
            end else begin
              data0_q.data  <= mem_req_q.rw ? 128'h0 : bus.mem_data_i.data;
              data0_q.ready <= 1'b1;
            end
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            if (owner_q) begin
              data1_q <= '{data: 128'h0, ready: 1'b1};
            end else begin
              data0_q <= '{data: 128'h0, ready: 1'b1};
            end
            err_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        RESP: begin
          data0_q <= '0;
          data1_q <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= owner_q;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_o = mem_req_q;
  assign bus.data0_o   = data0_q;
  assign bus.data1_o   = data1_q;
  assign owner_o       = owner_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: memory stub, per-port request drivers, and a
// scoreboard of expected responses and grant order.

module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int unsigned TB_TIMEOUT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_mem_arbiter_if bus();
  logic       owner_o;
  logic       busy_o;
  logic       err_o;
  logic [1:0] state_o;

  cache_mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .owner_o (owner_o),
    .busy_o  (busy_o),
    .err_o   (err_o),
    .state_o (state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int mem_valid_cnt = 0;

  logic [128:0] exp0_q[$];     // {err, data}
  logic [128:0] exp1_q[$];
  logic         exp_grant_q[$];

  logic [127:0] ref_mem [logic [31:0]];
  logic [127:0] mem_arr [logic [31:0]];
  logic         mem_mute = 1'b0;
  int           mem_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req_o.valid) begin
        mem_valid_cnt++;
        if (exp_grant_q.size() > 0) check_eq("grant_order", owner_o, exp_grant_q.pop_front());
      end
      if (bus.data0_o.ready || bus.data1_o.ready) begin
        resp_cnt++;
        check_eq("resp_owner", owner_o, bus.data1_o.ready);
        check_eq("one_ready", bus.data0_o.ready & bus.data1_o.ready, 0);
      end
      if (err_o) check_eq("err_has_resp", bus.data0_o.ready | bus.data1_o.ready, 1);
    end
  end

  // ---------------- memory stub ----------------
  initial begin
    logic [31:0]  a;
    logic [127:0] wd;
    logic [127:0] rd;
    logic         rw;
    bus.mem_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req_o.valid && !mem_mute && !rst) begin
        a  = bus.mem_req_o.addr;
        wd = bus.mem_req_o.data;
        rw = bus.mem_req_o.rw;
        repeat (1 + mem_lat) @(posedge clk);
        #1;
        if (rw) begin
          mem_arr[a] = wd;
          rd = {$urandom, $urandom, $urandom, $urandom};  // junk the arbiter must drop
        end else begin
          rd = mem_arr.exists(a) ? mem_arr[a] : 128'h0;
        end
        bus.mem_data_i = '{data: rd, ready: 1'b1};
        @(posedge clk);
        #1;
        bus.mem_data_i = '0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_txn(input int port, input logic [31:0] addr, input logic [127:0] wdata,
                        input logic rw, input logic exp_err, input int exp_lat);
    logic [127:0] expd;
    logic [128:0] e;
    logic         got;
    int           start;
    mem_data_type rsp;
    if (rw || exp_err) expd = 128'h0;
    else expd = ref_mem.exists(addr) ? ref_mem[addr] : 128'h0;
    if (rw && !exp_err) ref_mem[addr] = wdata;
    if (port == 0) exp0_q.push_back({exp_err, expd});
    else exp1_q.push_back({exp_err, expd});
    start = cyc;
    if (port == 0) bus.req0_i = '{addr: addr, data: wdata, rw: rw, valid: 1'b1};
    else bus.req1_i = '{addr: addr, data: wdata, rw: rw, valid: 1'b1};
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      rsp = (port == 0) ? bus.data0_o : bus.data1_o;
      if (rsp.ready) begin
        got = 1'b1;
        break;
      end
    end
    check_eq($sformatf("p%0d_resp_seen", port), got, 1);
    if (port == 0) e = exp0_q.pop_front();
    else e = exp1_q.pop_front();
    if (got) begin
      check_eq($sformatf("p%0d_data", port), rsp.data, e[127:0]);
      check_eq($sformatf("p%0d_err", port), err_o, e[128]);
      check_eq($sformatf("p%0d_owner", port), owner_o, port[0]);
      if (exp_lat > 0) check_eq($sformatf("p%0d_latency", port), cyc - start, exp_lat);
    end
    if (port == 0) bus.req0_i = '0;
    else bus.req1_i = '0;
  endtask

  task automatic stray_ready(input string tag);
    int r;
    r = resp_cnt;
    bus.mem_data_i = '{data: {$urandom, $urandom, $urandom, $urandom}, ready: 1'b1};
    idle(1);
    bus.mem_data_i = '0;
    idle(3);
    check_eq({tag, "_no_resp"}, resp_cnt - r, 0);
    check_eq({tag, "_state"}, state_o, 2'd0);
    check_eq({tag, "_busy"}, busy_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mv;
    int r;
    logic [127:0] v;
    bus.req0_i = '0;
    bus.req1_i = '0;
    for (int i = 0; i < 64; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[32'(i * 16)] = v;
      mem_arr[32'(i * 16)] = v;
    end

    // reset values
    idle(2);
    check_eq("rst_state", state_o, 2'd0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_owner", owner_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_mem_req", bus.mem_req_o, 0);
    check_eq("rst_data0", bus.data0_o, 0);
    check_eq("rst_data1", bus.data1_o, 0);
    rst = 1'b0;
    idle(1);

    // port 0 read
    mv = mem_valid_cnt;
    r  = resp_cnt;
    exp_grant_q.push_back(1'b0);
    do_txn(0, 32'h40, 128'h0, 1'b0, 1'b0, 3);
    idle(1);
    check_eq("t1_mem_valid_cycles", mem_valid_cnt - mv, 1);
    check_eq("t1_resp_count", resp_cnt - r, 1);

    // port 1 write then read-back
    do_txn(1, 32'h100, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 1'b1, 1'b0, 3);
    idle(1);
    do_txn(1, 32'h100, 128'h0, 1'b0, 1'b0, 3);
    idle(1);

    // simultaneous requests, four rounds
    r = resp_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_grant_q.push_back(1'b0);
      exp_grant_q.push_back(1'b1);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) do_txn(0, 32'h200 + 32'(i * 16), 128'h0, 1'b0, 1'b0, 0);
      end
      begin
        for (int i = 0; i < 4; i++) do_txn(1, 32'h300 + 32'(i * 16), 128'h0, 1'b0, 1'b0, 0);
      end
    join
    idle(2);
    check_eq("t3_resp_count", resp_cnt - r, 8);

    // memory ready in the last WAIT cycle beats the watchdog
    mem_lat = 2;
    do_txn(1, 32'h80, 128'h0, 1'b0, 1'b0, 5);
    idle(1);

    // memory ready one cycle too late: timeout, then the late pulse is dropped
    mem_lat = 3;
    do_txn(0, 32'h90, 128'h0, 1'b0, 1'b1, 5);
    idle(1);
    r = resp_cnt;
    idle(3);
    check_eq("late_no_resp", resp_cnt - r, 0);
    check_eq("late_state", state_o, 2'd0);
    mem_lat = 0;

    // silent memory: timeout
    mem_mute = 1'b1;
    do_txn(0, 32'h40, 128'h0, 1'b0, 1'b1, TB_TIMEOUT + 2);
    mem_mute = 1'b0;
    idle(1);
    check_eq("to_state_idle", state_o, 2'd0);
    check_eq("to_busy", busy_o, 0);
    stray_ready("stray_after_to");
    stray_ready("stray_idle");

    // reset mid-WAIT (last grant is port 0 here, so the tie below proves the pointer reset)
    mem_mute = 1'b1;
    bus.req1_i = '{addr: 32'h120, data: 128'h0, rw: 1'b0, valid: 1'b1};
    idle(3);
    check_eq("rw_in_wait", state_o, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rw_busy", busy_o, 0);
    check_eq("rw_owner", owner_o, 0);
    check_eq("rw_err", err_o, 0);
    check_eq("rw_state", state_o, 2'd0);
    check_eq("rw_mem_req", bus.mem_req_o, 0);
    check_eq("rw_data0", bus.data0_o, 0);
    check_eq("rw_data1", bus.data1_o, 0);
    bus.req1_i = '0;
    mem_mute = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    stray_ready("stray_after_rst");

    exp_grant_q.push_back(1'b0);
    exp_grant_q.push_back(1'b1);
    fork
      do_txn(0, 32'h10, 128'h0, 1'b0, 1'b0, 0);
      do_txn(1, 32'h20, 128'h0, 1'b0, 1'b0, 0);
    join
    idle(1);
    do_txn(1, 32'h100, 128'h0, 1'b0, 1'b0, 3);
    idle(2);

    check_eq("scoreboard_empty", exp0_q.size() + exp1_q.size() + exp_grant_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end expected end by 500000");
    $fatal(1);
  end

endmodule
